// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// Words stream back-to-back with no idle gap when the buffer is refilled in time.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             last,
    output logic             busy,
    output logic             dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;
    logic             at_end;
    logic             xfer;

    // Handshake: a word is taken on an edge where load_valid && load_ready.
    // load_ready is low while held in reset so nothing is accepted then.
    assign load_ready = !hold_full && clear_n;
    assign accept     = load_valid && load_ready;
    assign at_end     = (state == SHIFT) && (cnt == LAST_CNT);
    assign xfer       = hold_full && ((state == IDLE) || at_end);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (xfer) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        if (xfer) begin
            state_nxt = SHIFT;
            sh_nxt    = hold;
            cnt_nxt   = '0;
        end else if (state == SHIFT) begin
            if (at_end) begin
                state_nxt = IDLE;
                sh_nxt    = '0;
                cnt_nxt   = '0;
            end else begin
                // Move the next bit toward the output end, back-filling with zero.
                if (MSB_FIRST) sh_nxt = {sh[WIDTH-2:0], 1'b0};
                else           sh_nxt = {1'b0, sh[WIDTH-1:1]};
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    assign so        = (state == SHIFT) && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
    assign so_valid  = (state == SHIFT);
    assign last      = at_end;
    assign busy      = (state == SHIFT) || hold_full;
    assign dbg_state = state;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: one MSB-first and one LSB-first instance, scoreboard of
// expected serial bits (with last flags) pushed at accept and popped per valid bit.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [7:0] din_m, din_l;
    logic       lv_m, lv_l;
    logic       ready_m, so_m, sv_m, last_m, busy_m, st_m;
    logic       ready_l, so_l, sv_l, last_l, busy_l, st_l;

    int n_cmp = 0;
    int n_err = 0;
    int run[2];
    int last_run[2];
    int w;

    logic [1:0] exp_mq[$];
    logic [1:0] exp_lq[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clear_n(clear_n), .din(din_m), .load_valid(lv_m),
        .load_ready(ready_m), .so(so_m), .so_valid(sv_m), .last(last_m),
        .busy(busy_m), .dbg_state(st_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clear_n(clear_n), .din(din_l), .load_valid(lv_l),
        .load_ready(ready_l), .so(so_l), .so_valid(sv_l), .last(last_l),
        .busy(busy_l), .dbg_state(st_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare each valid serial bit against the queue head.
    task automatic mon(input bit k, input logic s, input logic v, input logic l);
        logic [1:0] e;
        int         qs;
        qs = k ? exp_lq.size() : exp_mq.size();
        if (v) begin
            run[k]++;
            check(k ? "lsb_pending" : "msb_pending", 32'(qs != 0), 1);
            if (qs != 0) begin
                e = k ? exp_lq.pop_front() : exp_mq.pop_front();
                check(k ? "lsb_so" : "msb_so", s, e[0]);
                check(k ? "lsb_last" : "msb_last", l, e[1]);
            end
        end else begin
            if (run[k] != 0) last_run[k] = run[k];
            run[k] = 0;
            check(k ? "lsb_idle_out" : "msb_idle_out", {s, l}, 0);
        end
    endtask

    always @(negedge clk) begin
        if (clear_n === 1'b1) begin
            mon(1'b0, so_m, sv_m, last_m);
            mon(1'b1, so_l, sv_l, last_l);
        end else begin
            run[0] = 0;
            run[1] = 0;
        end
    end

    // Driver: present a word, wait (bounded) for ready, push expected bits at accept.
    task automatic send(input bit k, input logic [7:0] wd, output int waited);
        waited = 0;
        if (k) begin din_l = wd; lv_l = 1'b1; end
        else   begin din_m = wd; lv_m = 1'b1; end
        while (!(k ? ready_l : ready_m) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("send_timeout", 32'(waited < 100), 1);
        @(posedge clk);
        if (waited < 100) begin
            for (int i = 0; i < 8; i++) begin
                if (k) exp_lq.push_back({i == 7, wd[i]});
                else   exp_mq.push_back({i == 7, wd[7-i]});
            end
        end
        #1;
        if (k) lv_l = 1'b0;
        else   lv_m = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_mq.size() != 0 || exp_lq.size() != 0 || busy_m || busy_l) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 32'(n < 300), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b1;
        din_m = '0; din_l = '0; lv_m = 1'b0; lv_l = 1'b0;
        run[0] = 0; run[1] = 0; last_run[0] = 0; last_run[1] = 0;

        // Reset asserted between edges must clear outputs without a clock.
        #2 clear_n = 1'b0;
        #1 check("rst_async_outs", {so_m, sv_m, last_m, busy_m, ready_m}, 0);
        check("rst_async_state", st_m, 0);
        @(posedge clk); @(posedge clk);
        #3 clear_n = 1'b1;
        #1 check("rst_release_ready", {ready_m, ready_l}, 2'b11);
        @(posedge clk); #1;

        // Single word 0xA5, MSB first.
        send(1'b0, 8'hA5, w);
        check("single_lat_sv", sv_m, 0);
        check("single_lat_busy", busy_m, 1);
        check("single_lat_ready", ready_m, 0);
        @(posedge clk); #1;
        check("single_first_sv", sv_m, 1);
        check("single_ready_back", ready_m, 1);
        check("single_state", st_m, 1);
        wait_idle();
        check("single_run", last_run[0], 8);
        check("single_idle", {so_m, sv_m, busy_m, st_m}, 0);

        // Back-to-back 0xA5, 0x3C, then backpressure with changing din.
        send(1'b0, 8'hA5, w);
        send(1'b0, 8'h3C, w);
        check("b2b_accept_edge3", w, 1);
        for (int i = 0; i < 7; i++) begin
            din_m = 8'($urandom_range(0, 255));
            lv_m  = 1'b1;
            check("bp_ready_low", ready_m, 0);
            @(posedge clk); #1;
        end
        check("bp_ready_back", ready_m, 1);
        lv_m = 1'b0;
        wait_idle();
        check("b2b_run", last_run[0], 16);

        // Mid-frame reset with 0x3C waiting in the holding buffer.
        send(1'b0, 8'hA5, w);
        send(1'b0, 8'h3C, w);
        @(posedge clk);
        @(negedge clk);
        #1 clear_n = 1'b0;
        #1 check("midrst_outs", {so_m, sv_m, last_m, busy_m, ready_m}, 0);
        exp_mq.delete();
        @(posedge clk); @(posedge clk);
        #2 clear_n = 1'b1;
        #1 check("midrst_release_ready", ready_m, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_resume", {sv_m, busy_m}, 0);
        end
        send(1'b0, 8'hFF, w);
        wait_idle();
        check("ff_run", last_run[0], 8);

        // LSB-first instance.
        send(1'b1, 8'h01, w);
        wait_idle();
        check("lsb_run", last_run[1], 8);
        for (int i = 0; i < 3; i++) send(1'b1, 8'($urandom_range(0, 255)), w);
        wait_idle();
        check("lsb_b2b_run", last_run[1], 24);

        // Random words with random gaps on the MSB-first instance.
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'($urandom_range(0, 255)), w);
            repeat ($urandom_range(0, 10)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        check("final_idle", {busy_m, busy_l, sv_m, sv_l}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
